// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the 1-to-4 stream demultiplexer.
//   SEL_*    channel select codes carried with each beat ({s1,s0})
//   state_t  one-entry holding register state
//   sel_onehot  maps a select code to its one-hot channel mask
package demux_pkg;

  localparam int NUM_CH = 4;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_t;

  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, rst_n  clock / async active-low reset
//   inc         count one event this cycle
//   clr         synchronous clear; beats a simultaneous inc
//   q           current count, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                q <= '0;
    else if (clr)              q <= '0;
    else if (inc && (q != '1)) q <= q + 1'b1;
  end

endmodule

// File: rtl/demux_1to4_stream.sv
// demux_1to4_stream: registered 1-to-4 stream demultiplexer.
//   One-entry holding stage; each accepted beat is steered to channel {s1,s0}
//   (00=a, 01=b, 10=c, 11=d) and delivered the following cycle.
//   clk, rst_n          clock / async active-low reset
//   in_data, s1, s0     beat payload and its channel select
//   in_valid, in_ready  upstream handshake
//   out_data            held payload, shared by all channels
//   out_valid[3:0]      one-hot per channel (bit0=a .. bit3=d)
//   out_ready[3:0]      per-channel sink ready
//   cnt_clr             synchronous clear of the delivered-beat counters
//   cnt                 four CNT_W counters, a in the low slice
module demux_1to4_stream
  import demux_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [W-1:0]            in_data,
  input  logic                    s1,
  input  logic                    s0,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [W-1:0]            out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  input  logic                    cnt_clr,
  output logic [NUM_CH*CNT_W-1:0] cnt
);

  state_t                         st;
  logic [1:0]                     sel_q;
  logic                           drain;
  logic                           load;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_arr;

  // out_valid is zero unless FULL, so masking with out_ready picks only the
  // selected channel; deselected readies can never drain the entry.
  assign drain    = |(out_valid & out_ready);
  assign in_ready = (st == ST_EMPTY) || drain;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_EMPTY;
      out_data  <= '0;
      sel_q     <= SEL_A;
      out_valid <= '0;
    end else begin
      case (st)
        ST_EMPTY: begin
          if (load) begin
            st        <= ST_FULL;
            out_data  <= in_data;
            sel_q     <= {s1, s0};
            out_valid <= sel_onehot({s1, s0});
          end
        end
        ST_FULL: begin
          // Without a drain everything holds: select pins and in_valid are
          // ignored so out_valid is never retracted early.
          if (load) begin
            out_data  <= in_data;
            sel_q     <= {s1, s0};
            out_valid <= sel_onehot({s1, s0});
          end else if (drain) begin
            st        <= ST_EMPTY;
            out_valid <= '0;
          end
        end
        default: begin
          st        <= ST_EMPTY;
          out_valid <= '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (out_valid[i] & out_ready[i]),
      .clr   (cnt_clr),
      .q     (cnt_arr[i])
    );
  end

  assign cnt = cnt_arr;

endmodule

// File: tb/tb_demux_1to4_stream.sv
module tb_demux_1to4_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       s1, s0, in_valid, cnt_clr;
  logic [3:0] out_ready;

  logic       ir1, ir2;
  logic [7:0] od1, od2;
  logic [3:0] ov1, ov2;
  logic [31:0] cnt1;
  logic [7:0]  cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Same stimulus drives both; the second copy has 2-bit counters to reach saturation.
  demux_1to4_stream #(.W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .s1(s1), .s0(s0),
    .in_valid(in_valid), .in_ready(ir1), .out_data(od1), .out_valid(ov1),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .cnt(cnt1));

  demux_1to4_stream #(.W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .s1(s1), .s0(s0),
    .in_valid(in_valid), .in_ready(ir2), .out_data(od2), .out_valid(ov2),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .cnt(cnt2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: a queue holding at most one beat plus delivery tallies.
  typedef struct packed { logic [7:0] d; logic [1:0] s; } beat_t;
  beat_t      mq[$];
  logic [7:0] m_last;
  int         m_cnt1[4], m_cnt2[4];
  bit         m_dlv, m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_last = 8'h00;
      for (int i = 0; i < 4; i++) begin m_cnt1[i] = 0; m_cnt2[i] = 0; end
    end else begin
      m_dlv = (mq.size() != 0) && out_ready[mq[0].s];
      m_acc = in_valid && ((mq.size() == 0) || m_dlv);
      if (cnt_clr) begin
        for (int i = 0; i < 4; i++) begin m_cnt1[i] = 0; m_cnt2[i] = 0; end
      end else if (m_dlv) begin
        if (m_cnt1[mq[0].s] < 255) m_cnt1[mq[0].s]++;
        if (m_cnt2[mq[0].s] < 3)   m_cnt2[mq[0].s]++;
      end
      if (m_dlv) void'(mq.pop_front());
      if (m_acc) begin
        mq.push_back('{d: in_data, s: {s1, s0}});
        m_last = in_data;
      end
    end
  end

  logic [3:0]  e_ov;
  logic        e_ir;
  logic [31:0] e_c1;
  logic [7:0]  e_c2;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      e_ov = (mq.size() != 0) ? (4'b0001 << mq[0].s) : 4'b0000;
      e_ir = (mq.size() == 0) || out_ready[mq[0].s];
      for (int i = 0; i < 4; i++) begin
        e_c1[i*8 +: 8] = m_cnt1[i][7:0];
        e_c2[i*2 +: 2] = m_cnt2[i][1:0];
      end
      chk("m_out_valid", {28'd0, ov1}, {28'd0, e_ov});
      chk("m_in_ready",  {31'd0, ir1}, {31'd0, e_ir});
      chk("m_out_data",  {24'd0, od1}, {24'd0, m_last});
      chk("m_cnt",       cnt1, e_c1);
      chk("m2_out_valid", {28'd0, ov2}, {28'd0, e_ov});
      chk("m2_in_ready",  {31'd0, ir2}, {31'd0, e_ir});
      chk("m2_cnt",       {24'd0, cnt2}, {24'd0, e_c2});
    end
  end

  task automatic tick();   @(posedge clk); #1; endtask
  task automatic at_neg(); @(negedge clk); #1; endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
  endtask

  logic [7:0] rt_data [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_data = 8'h00; s1 = 0; s0 = 0; in_valid = 0; cnt_clr = 0;
    out_ready = 4'b0000;
    #12;
    chk("rst_out_valid", {28'd0, ov1}, 32'h0);
    chk("rst_cnt", cnt1, 32'h0);
    chk("rst_out_data", {24'd0, od1}, 32'h0);
    #1 rst_n = 1'b1;
    at_neg();
    chk("rst_in_ready", {31'd0, ir1}, 32'h1);

    // Routing: one beat per channel, back to back.
    clr_cnt();
    out_ready = 4'b1111; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = rt_data[i]; {s1, s0} = 2'(i);
      tick(); at_neg();
      chk("route_valid", {28'd0, ov1}, 32'(4'b0001 << i));
      chk("route_data",  {24'd0, od1}, {24'd0, rt_data[i]});
    end
    in_valid = 1'b0; tick(); at_neg();
    chk("route_cnt",  cnt1, 32'h01010101);
    chk("route_cnt2", {24'd0, cnt2}, 32'h55);

    // Backpressure on channel c.
    clr_cnt();
    in_data = 8'h55; {s1, s0} = 2'b10; in_valid = 1'b1; out_ready = 4'b1011;
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("bp_valid", {28'd0, ov1}, 32'h4);
      chk("bp_ready", {31'd0, ir1}, 32'h0);
      chk("bp_data",  {24'd0, od1}, 32'h55);
      tick();
    end
    out_ready = 4'b1111; tick(); at_neg();
    chk("bp_drained", {28'd0, ov1}, 32'h0);
    chk("bp_cnt_c", {24'd0, cnt1[23:16]}, 32'h1);

    // Back-to-back to channel b.
    clr_cnt();
    {s1, s0} = 2'b01; in_valid = 1'b1; out_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(8'h10 + i);
      #1 chk("b2b_in_ready", {31'd0, ir1}, 32'h1);
      tick();
    end
    in_valid = 1'b0; tick(); at_neg();
    chk("b2b_cnt_b",  {24'd0, cnt1[15:8]}, 32'h8);
    chk("b2b_cnt2_b", {30'd0, cnt2[3:2]}, 32'h3);

    // Saturation and clear priority on channel d.
    clr_cnt();
    {s1, s0} = 2'b11; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin in_data = 8'(8'h20 + i); tick(); end
    in_valid = 1'b0; tick(); at_neg();
    chk("sat_cnt2_d", {30'd0, cnt2[7:6]}, 32'h3);
    chk("sat_cnt_d",  {24'd0, cnt1[31:24]}, 32'h5);
    in_data = 8'h77; in_valid = 1'b1; tick();
    in_valid = 1'b0; cnt_clr = 1'b1; tick(); cnt_clr = 1'b0; at_neg();
    chk("clr_cnt_d",  {24'd0, cnt1[31:24]}, 32'h0);
    chk("clr_cnt2_d", {30'd0, cnt2[7:6]}, 32'h0);
    chk("clr_drained", {28'd0, ov1}, 32'h0);

    // Select glitch while stalled on channel a.
    clr_cnt();
    in_data = 8'h9A; {s1, s0} = 2'b00; in_valid = 1'b1; out_ready = 4'b1110;
    tick(); in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      {s1, s0} = 2'(i); tick(); at_neg();
      chk("glitch_valid", {28'd0, ov1}, 32'h1);
      chk("glitch_data",  {24'd0, od1}, 32'h9A);
    end
    out_ready = 4'b1111; tick(); at_neg();
    chk("glitch_cnt_a", {24'd0, cnt1[7:0]}, 32'h1);

    // Reset mid-beat: held beat discarded immediately.
    in_data = 8'hE5; {s1, s0} = 2'b10; in_valid = 1'b1; out_ready = 4'b0000;
    tick(); in_valid = 1'b0; #2;
    rst_n = 1'b0; #1;
    chk("mid_rst_valid", {28'd0, ov1}, 32'h0);
    chk("mid_rst_cnt",   cnt1, 32'h0);
    chk("mid_rst_data",  {24'd0, od1}, 32'h0);
    tick(); rst_n = 1'b1; at_neg();
    chk("mid_rst_ready", {31'd0, ir1}, 32'h1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
